// File: rtl/db_scan_ctrl.sv
// db_scan_ctrl: time-multiplexed debouncer for N_CH switches.
// A single free-running prescaler produces a tick that starts one scan.
// During a scan the FSM visits one channel per cycle and updates that
// channel's stable-count. Each debounced level flips only after its raw
// input has differed from it continuously for STABLE_TICKS visits.
module db_scan_ctrl #(
  parameter int N_CH         = 4,
  parameter int TICK_BITS    = 19,
  parameter int STABLE_TICKS = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] sw,
  output logic [N_CH-1:0] db,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            busy
);

  localparam int                   IDX_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(N_CH - 1);
  localparam logic [2:0]           CNT_LAST  = 3'(STABLE_TICKS - 1);
  localparam logic [TICK_BITS-1:0] PRESC_MAX = {TICK_BITS{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  // Synchronizer stages (not reset: they only carry the pin level).
  logic [N_CH-1:0]      sync_meta_q;
  logic [N_CH-1:0]      sync_q;

  logic [TICK_BITS-1:0] presc_q, presc_d;
  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [2:0]           cnt_q [N_CH];
  logic [2:0]           cnt_d [N_CH];
  logic [N_CH-1:0]      bnc_q, bnc_d;
  logic [N_CH-1:0]      db_q, db_d;
  logic [N_CH-1:0]      rise_q, rise_d;
  logic [N_CH-1:0]      fall_q, fall_d;
  logic                 busy_q, busy_d;

  logic                 tick_s;
  logic [N_CH-1:0]      visit_s;
  logic [N_CH-1:0]      same_s;

  // Two-flop synchronizer bringing the asynchronous switch pins into clk.
  always_ff @(posedge clk) begin
    sync_meta_q <= sw;
    sync_q      <= sync_meta_q;
  end

  // Per-channel decode: which channel is visited now, and which inputs match db.
  always_comb begin
    visit_s = {N_CH{1'b0}};
    same_s  = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      visit_s[i] = (state_q == ST_SCAN) && (idx_q == IDX_W'(i));
      same_s[i]  = (sync_q[i] == db_q[i]);
    end
  end

  // Prescaler and scan FSM next-state logic.
  always_comb begin
    presc_d = presc_q + TICK_BITS'(1);
    tick_s  = (presc_q == PRESC_MAX);
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (tick_s) begin
          state_d = ST_SCAN;
          idx_d   = {IDX_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
          idx_d   = idx_q;
        end
      end
      ST_SCAN: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = {IDX_W{1'b0}};
        end else begin
          state_d = ST_SCAN;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
    busy_d = (state_d == ST_SCAN);
  end

  // Channel update: stable-count on visit, bounce flag tracking, flip and edge pulses.
  always_comb begin
    cnt_d  = cnt_q;
    db_d   = db_q;
    bnc_d  = bnc_q;
    rise_d = {N_CH{1'b0}};
    fall_d = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      if (visit_s[i]) begin
        if (same_s[i] || bnc_q[i]) begin
          cnt_d[i] = 3'd0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]  = 3'd0;
          db_d[i]   = ~db_q[i];
          rise_d[i] = ~db_q[i];
          fall_d[i] = db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 3'd1;
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      // A matching cycle marks the channel dirty; setting wins over the visit clear.
      if (same_s[i]) begin
        bnc_d[i] = 1'b1;
      end else if (visit_s[i]) begin
        bnc_d[i] = 1'b0;
      end else begin
        bnc_d[i] = bnc_q[i];
      end
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= {TICK_BITS{1'b0}};
      state_q <= ST_IDLE;
      idx_q   <= {IDX_W{1'b0}};
      bnc_q   <= {N_CH{1'b0}};
      db_q    <= {N_CH{1'b0}};
      rise_q  <= {N_CH{1'b0}};
      fall_q  <= {N_CH{1'b0}};
      busy_q  <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= 3'd0;
      end
    end else begin
      presc_q <= presc_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      bnc_q   <= bnc_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign db   = db_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule
